// File: rtl/nrisc_control_fsm.sv
// nrisc_control_fsm
//   Multi-cycle control unit for the 8-bit nRISC core. It steps the shared
//   datapath through FETCH, DECODE, EXEC, MEM and WB. It handshakes with a
//   variable-latency memory via mem_ready and counts retired instructions.
//
// Ports
//   clock      in   system clock, rising edge
//   reset      in   asynchronous active-high reset (state IDLE, counter 0)
//   opcode     in   instruction register bits [7:5], valid from DECODE on
//   alu_zero   in   ALU zero flag (combinational from datapath)
//   mem_ready  in   memory completes the current access this cycle
//   pc_write   out  load PC
//   pc_src     out  0 = PC+1, 1 = PC + zero-extended imm
//   ir_write   out  load instruction register
//   mem_read   out  memory read request (held until mem_ready)
//   mem_write  out  memory write request (held until mem_ready)
//   iord       out  memory address source: 0 = PC, 1 = ALU result register
//   reg_write  out  register file write strobe
//   mem_to_reg out  write-back source: 0 = ALU result, 1 = memory data
//   alu_op     out  00 ADD, 01 SUB, 10 AND
//   alu_src_b  out  00 reg B, 01 zero-extended imm, 10 constant 1
//   halted     out  high while in HALT
//   retired    out  completed-instruction count, wraps modulo 256
//
// The control outputs are decoded from the state register and the opcode
// latched in DECODE. They are not registered, so that an asynchronous
// reset removes a pending memory request at once. Only the FETCH
// strobes and the BEQ pc_write also look at mem_ready or alu_zero.

module nrisc_control_fsm #(
  parameter logic [2:0] HALT_OP = 3'b111
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [2:0] opcode,
  input  logic       alu_zero,
  input  logic       mem_ready,
  output logic       pc_write,
  output logic       pc_src,
  output logic       ir_write,
  output logic       mem_read,
  output logic       mem_write,
  output logic       iord,
  output logic       reg_write,
  output logic       mem_to_reg,
  output logic [1:0] alu_op,
  output logic [1:0] alu_src_b,
  output logic       halted,
  output logic [7:0] retired
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_FETCH  = 3'd1,
    S_DECODE = 3'd2,
    S_EXEC   = 3'd3,
    S_MEM    = 3'd4,
    S_WB     = 3'd5,
    S_HALT   = 3'd6
  } state_t;

  localparam logic [2:0] OP_ADD  = 3'b000;
  localparam logic [2:0] OP_SUB  = 3'b001;
  localparam logic [2:0] OP_AND  = 3'b010;
  localparam logic [2:0] OP_LW   = 3'b011;
  localparam logic [2:0] OP_SW   = 3'b100;
  localparam logic [2:0] OP_ADDI = 3'b101;
  localparam logic [2:0] OP_BEQ  = 3'b110;

  localparam logic [1:0] ALU_ADD = 2'b00;
  localparam logic [1:0] ALU_SUB = 2'b01;
  localparam logic [1:0] ALU_AND = 2'b10;

  localparam logic [1:0] SRCB_REG = 2'b00;
  localparam logic [1:0] SRCB_IMM = 2'b01;

  state_t     state;
  logic [2:0] op_q;

  // State sequencing, opcode capture and retired-instruction counter.
  // The counter steps on the edge that leaves the final state of an instruction.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      op_q    <= 3'b000;
      retired <= 8'd0;
    end else begin
      case (state)
        S_IDLE: begin
          state <= S_FETCH;
        end
        S_FETCH: begin
          if (mem_ready) begin
            state <= S_DECODE;
          end else begin
            state <= S_FETCH;
          end
        end
        S_DECODE: begin
          op_q <= opcode;
          // HALT is checked first, so it wins even if HALT_OP aliases a listed opcode.
          if (opcode == HALT_OP) begin
            state <= S_HALT;
          end else begin
            state <= S_EXEC;
          end
        end
        S_EXEC: begin
          case (op_q)
            OP_LW, OP_SW: state <= S_MEM;
            OP_BEQ: begin
              state   <= S_FETCH;
              retired <= retired + 8'd1;
            end
            default: state <= S_WB;
          endcase
        end
        S_MEM: begin
          if (mem_ready) begin
            if (op_q == OP_LW) begin
              state <= S_WB;
            end else begin
              state   <= S_FETCH;
              retired <= retired + 8'd1;
            end
          end else begin
            state <= S_MEM;
          end
        end
        S_WB: begin
          state   <= S_FETCH;
          retired <= retired + 8'd1;
        end
        S_HALT: begin
          state <= S_HALT;
        end
        default: begin
          state <= S_IDLE;
        end
      endcase
    end
  end

  // Control-output decode from state, latched opcode and the two live flags.
  always_comb begin
    pc_write   = 1'b0;
    pc_src     = 1'b0;
    ir_write   = 1'b0;
    mem_read   = 1'b0;
    mem_write  = 1'b0;
    iord       = 1'b0;
    reg_write  = 1'b0;
    mem_to_reg = 1'b0;
    alu_op     = ALU_ADD;
    alu_src_b  = SRCB_REG;
    halted     = 1'b0;
    case (state)
      S_FETCH: begin
        mem_read = 1'b1;
        iord     = 1'b0;
        // The IR/PC load happens only on the edge that completes the read.
        if (mem_ready) begin
          ir_write = 1'b1;
          pc_write = 1'b1;
        end else begin
          ir_write = 1'b0;
          pc_write = 1'b0;
        end
      end
      S_EXEC: begin
        case (op_q)
          OP_SUB: begin
            alu_op    = ALU_SUB;
            alu_src_b = SRCB_REG;
          end
          OP_AND: begin
            alu_op    = ALU_AND;
            alu_src_b = SRCB_REG;
          end
          OP_LW, OP_SW, OP_ADDI: begin
            alu_op    = ALU_ADD;
            alu_src_b = SRCB_IMM;
          end
          OP_BEQ: begin
            // Compare by subtraction; take the branch only when the result is zero.
            alu_op    = ALU_SUB;
            alu_src_b = SRCB_REG;
            pc_src    = 1'b1;
            pc_write  = alu_zero;
          end
          default: begin
            alu_op    = ALU_ADD;
            alu_src_b = SRCB_REG;
          end
        endcase
      end
      S_MEM: begin
        iord = 1'b1;
        if (op_q == OP_LW) begin
          mem_read = 1'b1;
        end else begin
          mem_write = 1'b1;
        end
      end
      S_WB: begin
        reg_write = 1'b1;
        if (op_q == OP_LW) begin
          mem_to_reg = 1'b1;
        end else begin
          mem_to_reg = 1'b0;
        end
      end
      S_HALT: begin
        halted = 1'b1;
      end
      default: begin
        halted = 1'b0;
      end
    endcase
  end

endmodule
